// File: rtl/irq_entry_seq_pkg.sv
// Shared AVR core constants used by the interrupt entry sequencer.
package avr_constants;

   // SREG bit that globally enables interrupts
   localparam int SREG_I_BIT = 7;

   // Width of a latched interrupt index (up to 32 request lines)
   localparam int IRQ_IDX_W = 5;

   // Entry sequencer states; encodings are fixed so debug views stay stable
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PUSH_L = 2'd1,
      ST_PUSH_H = 2'd2,
      ST_VECTOR = 2'd3
   } irq_state_e;

endpackage

// File: rtl/irq_entry_seq_prio_enc.sv
// Lowest-index-first priority encoder for interrupt request lines.
module irq_prio_enc
   import avr_constants::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0]   req,
   output logic                 valid,
   output logic [IRQ_IDX_W-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = IRQ_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_entry_seq.sv
// Interrupt entry sequencer: pushes the return PC, clears SREG.I and
// vectors the core, stalling it for the three-cycle entry sequence.
module irq_entry_seq
   import avr_constants::*;
#(
   parameter int NUM_IRQ    = 8,
   parameter int PC_W       = 16,
   parameter int VEC_STRIDE = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               ena_i,
   input  logic [NUM_IRQ-1:0] irq_req_i,
   output logic [NUM_IRQ-1:0] irq_ack_o,
   input  logic               boundary_i,
   input  logic               i_flag_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [15:0]        sp_i,
   output logic               stall_o,
   output logic               ram_we_o,
   output logic [15:0]        ram_adr_o,
   output logic [7:0]         ram_data_o,
   output logic               sp_we_o,
   output logic               sp_pop_o,
   output logic [7:0]         sreg_we_o,
   output logic [7:0]         sreg_o,
   output logic               pc_load_o,
   output logic [PC_W-1:0]    pc_vec_o
);

   irq_state_e           state_q, state_d;
   logic [IRQ_IDX_W-1:0] idx_r;
   logic [PC_W-1:0]      pc_r;
   logic                 enc_valid;
   logic [IRQ_IDX_W-1:0] enc_idx;
   logic                 take;

   irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .req   (irq_req_i),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // Entry is only taken at an instruction boundary with interrupts enabled
   assign take = (state_q == ST_IDLE) && boundary_i && i_flag_i && enc_valid;

   // State register plus request/PC capture; ena_i low freezes everything
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_r   <= '0;
         pc_r    <= '0;
      end else if (ena_i) begin
         state_q <= state_d;
         if (take) begin
            idx_r <= enc_idx;
            pc_r  <= pc_i;
         end
      end
   end

   // Next state and output decode from registered state only
   always_comb begin
      state_d    = state_q;
      stall_o    = 1'b0;
      ram_we_o   = 1'b0;
      ram_adr_o  = '0;
      ram_data_o = '0;
      sp_we_o    = 1'b0;
      sp_pop_o   = 1'b0;
      sreg_we_o  = '0;
      sreg_o     = '0;
      pc_load_o  = 1'b0;
      pc_vec_o   = '0;
      irq_ack_o  = '0;
      case (state_q)
         ST_IDLE: begin
            if (take) state_d = ST_PUSH_L;
         end
         ST_PUSH_L: begin
            stall_o    = 1'b1;
            ram_we_o   = 1'b1;
            ram_adr_o  = sp_i;
            ram_data_o = pc_r[7:0];
            sp_we_o    = 1'b1;
            // Clear only the I bit so nested entries need an explicit re-enable
            sreg_we_o  = 8'(1 << SREG_I_BIT);
            sreg_o     = 8'h00;
            state_d    = ST_PUSH_H;
         end
         ST_PUSH_H: begin
            stall_o    = 1'b1;
            ram_we_o   = 1'b1;
            ram_adr_o  = sp_i;
            ram_data_o = 8'(pc_r >> 8);
            sp_we_o    = 1'b1;
            state_d    = ST_VECTOR;
         end
         ST_VECTOR: begin
            stall_o   = 1'b1;
            pc_load_o = 1'b1;
            // Truncation to PC_W gives the modulo wrap of the vector address
            pc_vec_o  = PC_W'((32'(idx_r) + 32'd1) * 32'(VEC_STRIDE));
            for (int i = 0; i < NUM_IRQ; i++)
               irq_ack_o[i] = (idx_r == IRQ_IDX_W'(i));
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_irq_entry_seq.sv
// Directed self-checking bench for irq_entry_seq (default and narrow configs).
module tb_irq_entry_seq;

   logic        clk, rst, ena;
   logic [7:0]  irq, ack;
   logic        bnd, iflg;
   logic [15:0] pc, sp;
   logic        stall, ram_we, sp_we, sp_pop, pc_load;
   logic [15:0] ram_adr, pc_vec;
   logic [7:0]  ram_data, sreg_we, sreg;

   logic        irq2, ack2, bnd2, iflg2;
   logic [11:0] pc2, pc_vec2;
   logic [15:0] sp2, ram_adr2;
   logic        stall2, ram_we2, sp_we2, sp_pop2, pc_load2;
   logic [7:0]  ram_data2, sreg_we2, sreg2;

   int checks = 0;
   int errors = 0;

   irq_entry_seq dut (
      .clk_i(clk), .rst_i(rst), .ena_i(ena), .irq_req_i(irq), .irq_ack_o(ack),
      .boundary_i(bnd), .i_flag_i(iflg), .pc_i(pc), .sp_i(sp), .stall_o(stall),
      .ram_we_o(ram_we), .ram_adr_o(ram_adr), .ram_data_o(ram_data),
      .sp_we_o(sp_we), .sp_pop_o(sp_pop), .sreg_we_o(sreg_we), .sreg_o(sreg),
      .pc_load_o(pc_load), .pc_vec_o(pc_vec)
   );

   irq_entry_seq #(.NUM_IRQ(1), .PC_W(12), .VEC_STRIDE(4)) dut2 (
      .clk_i(clk), .rst_i(rst), .ena_i(1'b1), .irq_req_i(irq2), .irq_ack_o(ack2),
      .boundary_i(bnd2), .i_flag_i(iflg2), .pc_i(pc2), .sp_i(sp2), .stall_o(stall2),
      .ram_we_o(ram_we2), .ram_adr_o(ram_adr2), .ram_data_o(ram_data2),
      .sp_we_o(sp_we2), .sp_pop_o(sp_pop2), .sreg_we_o(sreg_we2), .sreg_o(sreg2),
      .pc_load_o(pc_load2), .pc_vec_o(pc_vec2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle; inputs changed here are seen at the next edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; irq = 8'h00; bnd = 1'b0; iflg = 1'b0; pc = '0; sp = '0;
      irq2 = 1'b0; bnd2 = 1'b0; iflg2 = 1'b0; pc2 = '0; sp2 = '0;
      step(); step();
      check("rst_stall",   32'(stall),   32'h0);
      check("rst_we",      32'(ram_we),  32'h0);
      check("rst_vec",     32'(pc_vec),  32'h0);
      check("rst_ack",     32'(ack),     32'h0);
      check("rst_stall2",  32'(stall2),  32'h0);
      rst = 1'b0;

      // Single request, line 2
      irq = 8'h04; iflg = 1'b1; bnd = 1'b1; pc = 16'h1234; sp = 16'h045F;
      #1;
      check("idle_adr",    32'(ram_adr), 32'h0);
      check("idle_stall",  32'(stall),   32'h0);
      step();
      check("pl_stall",    32'(stall),   32'h1);
      check("pl_we",       32'(ram_we),  32'h1);
      check("pl_adr",      32'(ram_adr), 32'h045F);
      check("pl_data",     32'(ram_data),32'h34);
      check("pl_spwe",     32'(sp_we),   32'h1);
      check("pl_pop",      32'(sp_pop),  32'h0);
      check("pl_sregwe",   32'(sreg_we), 32'h80);
      check("pl_sreg",     32'(sreg),    32'h00);
      check("pl_pcload",   32'(pc_load), 32'h0);
      sp = 16'h045E;
      step();
      check("ph_adr",      32'(ram_adr), 32'h045E);
      check("ph_data",     32'(ram_data),32'h12);
      check("ph_spwe",     32'(sp_we),   32'h1);
      check("ph_sregwe",   32'(sreg_we), 32'h00);
      sp = 16'h045D;
      step();
      check("vec_load",    32'(pc_load), 32'h1);
      check("vec_addr",    32'(pc_vec),  32'h0006);
      check("vec_ack",     32'(ack),     32'h04);
      check("vec_we",      32'(ram_we),  32'h0);
      check("vec_stall",   32'(stall),   32'h1);
      iflg = 1'b0;
      step();
      check("end_stall",   32'(stall),   32'h0);
      check("end_ack",     32'(ack),     32'h00);
      check("end_vec",     32'(pc_vec),  32'h0);
      step();
      check("noreent",     32'(stall),   32'h0);

      // Priority: lines 5 and 7, request dropped during PUSH_L
      irq = 8'hA0; iflg = 1'b1; pc = 16'h0100;
      step();
      check("pri_pl",      32'(stall),   32'h1);
      irq = 8'h00;
      step();
      check("pri_ph_data", 32'(ram_data),32'h01);
      step();
      check("pri_ack",     32'(ack),     32'h20);
      check("pri_vec",     32'(pc_vec),  32'h000C);
      iflg = 1'b0;
      step();
      check("pri_end",     32'(stall),   32'h0);

      // Gating by I flag and boundary
      irq = 8'h01; iflg = 1'b0; bnd = 1'b1; pc = 16'h00AA;
      step();
      check("gate_i",      32'(stall),   32'h0);
      check("gate_i_we",   32'(ram_we),  32'h0);
      iflg = 1'b1; bnd = 1'b0;
      step();
      check("gate_b",      32'(stall),   32'h0);
      bnd = 1'b1;
      step();
      check("gate_go",     32'(stall),   32'h1);
      check("gate_data",   32'(ram_data),32'hAA);

      // Clock enable low for two cycles during PUSH_H
      step();
      check("ena_ph",      32'(ram_data),32'h00);
      ena = 1'b0;
      step();
      check("ena_hold1",   32'(sp_we),   32'h1);
      check("ena_hold1l",  32'(pc_load), 32'h0);
      step();
      check("ena_hold2",   32'(ram_we),  32'h1);
      ena = 1'b1;
      step();
      check("ena_ack",     32'(ack),     32'h01);
      check("ena_vec",     32'(pc_vec),  32'h0002);
      iflg = 1'b0;
      step();
      check("ena_end",     32'(stall),   32'h0);

      // Asynchronous reset mid PUSH_H
      iflg = 1'b1; irq = 8'h08;
      step();
      step();
      check("ar_ph",       32'(ram_we),  32'h1);
      iflg = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("ar_stall",    32'(stall),   32'h0);
      check("ar_we",       32'(ram_we),  32'h0);
      check("ar_spwe",     32'(sp_we),   32'h0);
      rst = 1'b0;
      step();
      check("ar_idle",     32'(stall),   32'h0);
      check("ar_load",     32'(pc_load), 32'h0);

      // Narrow config: PC_W=12, one line, stride 4, SP wrap
      irq2 = 1'b1; iflg2 = 1'b1; bnd2 = 1'b1; pc2 = 12'hABC; sp2 = 16'h0000;
      step();
      check("w_pl_adr",    32'(ram_adr2), 32'h0000);
      check("w_pl_data",   32'(ram_data2),32'hBC);
      check("w_pl_sreg",   32'(sreg_we2), 32'h80);
      sp2 = 16'hFFFF; iflg2 = 1'b0;
      step();
      check("w_ph_adr",    32'(ram_adr2), 32'hFFFF);
      check("w_ph_data",   32'(ram_data2),32'h0A);
      step();
      check("w_vec",       32'(pc_vec2),  32'h004);
      check("w_ack",       32'(ack2),     32'h1);
      step();
      check("w_end",       32'(stall2),   32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_entry_seq.md
# irq_entry_seq

Interrupt entry sequencer for the AVR core. It takes vectored interrupt requests at instruction boundaries when SREG.I is set, and stalls the core while it runs the entry sequence. In that sequence it pushes the return PC to the stack through the data-RAM write port, drives the stack-pointer decrement and SREG.I clear strobes of the internal I/O register file, and finally loads the PC with the vector address. It sits between the core control unit, the I/O register file and the data-RAM write mux.

## Interface
- NUM_IRQ, 8, number of request lines, 1..32
- PC_W, 16, program counter width, 9..16; pushed as two bytes, upper bits zero-extended
- VEC_STRIDE, 2, vector spacing in words; vector = (index+1)*VEC_STRIDE

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- ena_i  in  1  clock enable; low freezes all state
- irq_req_i  in  NUM_IRQ  level requests, bit 0 highest priority
- irq_ack_o  out  NUM_IRQ  one-hot acknowledge of the serviced line, 1 cycle
- boundary_i  in  1  core is at an instruction boundary
- i_flag_i  in  1  SREG.I (bit 7) from the register file
- pc_i  in  PC_W  return address at the boundary
- sp_i  in  16  current stack pointer, zero-extended
- stall_o  out  1  hold core fetch/execute
- ram_we_o  out  1  data-RAM write strobe
- ram_adr_o  out  16  data-RAM write address
- ram_data_o  out  8  data-RAM write data
- sp_we_o  out  1  SP inc/dec enable
- sp_pop_o  out  1  always 0 (push)
- sreg_we_o  out  8  SREG per-bit write enables
- sreg_o  out  8  SREG write values
- pc_load_o  out  1  load PC with pc_vec_o
- pc_vec_o  out  PC_W  vector address

## Operation
- States: IDLE, PUSH_L, PUSH_H, VECTOR.
- IDLE → PUSH_L requires all of:
  - ena_i=1, boundary_i=1, i_flag_i=1;
  - irq_req_i≠0.
- On that transition the block latches:
  - idx_r = lowest set request bit;
  - pc_r = pc_i.
- Requests that change after the latch are ignored until IDLE is re-entered.
- PUSH_L drives:
  - ram_we_o=1, ram_adr_o=sp_i, ram_data_o=pc_r[7:0];
  - sp_we_o=1;
  - sreg_we_o=8'h80, sreg_o=8'h00 (clears I).
- PUSH_L → PUSH_H.
- PUSH_H drives ram_we_o=1, ram_adr_o=sp_i (already decremented), ram_data_o=zero-extended pc_r[PC_W-1:8], sp_we_o=1. PUSH_H → VECTOR.
- VECTOR drives:
  - pc_load_o=1;
  - pc_vec_o=((idx_r+1)*VEC_STRIDE) mod 2^PC_W;
  - irq_ack_o bit idx_r = 1.
- VECTOR → IDLE.
- stall_o=1 whenever state≠IDLE.
- boundary_i, i_flag_i and irq_req_i are don't-care outside IDLE.
- All outputs other than stall_o are 0 in IDLE (pc_vec_o=0, ram_adr_o=0).
- SP wrap: sp_i=0 pushes to address 0, then 16'hFFFF. No checks are made.
- Re-entry: I is cleared in PUSH_L, so a pending request with I still low stays in IDLE. Re-entry needs i_flag_i=1 again, e.g. after RETI.

## Timing
- Reset: state=IDLE, idx_r=0, pc_r=0, all outputs 0. Asserting reset mid-sequence aborts immediately; pushes already made are not undone.
- An entry decided at edge T gives:
  - PUSH_L in cycle T+1;
  - PUSH_H in cycle T+2;
  - VECTOR in cycle T+3;
  - IDLE in cycle T+4.
  - Total is 3 stall cycles. The earliest next entry is decided at the end of T+4.
- ena_i=0 holds the state. Outputs of the current state stay asserted but have no effect, because the register file and RAM also use ena_i.
- All outputs are decoded from registered state and idx_r/pc_r, plus sp_i, which is a flop output. There are no combinational paths from irq_req_i to outputs.

## Structure
- Shared constants in avr_constants: SREG_I_BIT=7 and the state encodings (IDLE=0, PUSH_L=1, PUSH_H=2, VECTOR=3).
- Sub-module irq_prio_enc (NUM_IRQ): combinational lowest-index-first encoder giving a valid flag and a 5-bit index.
- The top level holds the FSM, latches and output decode.

## Test plan
- Reset then single request: irq_req_i=8'h04, i_flag_i=1, boundary_i=1, pc_i=16'h1234, sp_i=16'h045F → writes 8'h34@045F and then 8'h12@045E, two sp_we_o pulses, sreg_we_o=8'h80/sreg_o=0 in T+1, pc_vec_o=16'h0006 and irq_ack_o=8'h04 in T+3.
- Priority: irq_req_i=8'hA0 → irq_ack_o=8'h20, pc_vec_o=16'h000C. Dropping the request during PUSH_L still completes the sequence with index 5.
- Gating: i_flag_i=0 or boundary_i=0 with a request pending → no stall, no writes. Setting i_flag_i=1 then starts entry on the next boundary.
- ena_i low for 2 cycles during PUSH_H → state held, sequence resumes and completes. Total cycles = 3 + 2.
- Async reset asserted in PUSH_H, mid-cycle → all outputs 0 before the next clock edge; after release, state is IDLE.
- Wrap and width: PC_W=12, pc_i=12'hABC, sp_i=0 → 8'hBC@0000, 8'h0A@FFFF; NUM_IRQ=1, VEC_STRIDE=4 → pc_vec_o=12'h004.
